// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: captures a word on load, shifts it out MSB first with a valid strobe.
// Optional even-parity trailer bit is compiled in when PISO_PARITY_EN is defined.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs depend only on registered state, never on load/din directly.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif
    ready      = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          shreg_d  = din;
          cnt_d    = '0;
`ifdef PISO_PARITY_EN
          parity_d = ^din;
`endif
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sout       = shreg_q[WIDTH-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
        shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_DONE;
`endif
        end
      end

`ifdef PISO_PARITY_EN
      S_PARITY: begin
        sout       = parity_q;
        sout_valid = 1'b1;
        busy       = 1'b1;
        state_d    = S_DONE;
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a frame-level queue model predicts every output cycle,
// and a SIPO-style receiver rebuilds each word from sout/sout_valid.
module tb_piso_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         ready, sout, sout_valid, busy, done;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Each queued entry is one future non-idle cycle: {done, valid, sout}.
  logic [2:0]   exp_q[$];
  logic [W-1:0] sent_q[$];
  logic [W-1:0] rx_word = '0;
  int           rx_n    = 0;
  int           accepts = 0;
  int           words_ok = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs just after a rising edge, then check at the following falling edge.
  task automatic step(input logic r, input logic l, input logic [W-1:0] d);
    logic [4:0] exp_v;
    logic [4:0] got_v;
    logic [2:0] e;
    bit         idle;
    @(posedge clk);
    #1;
    rst  = r;
    load = l;
    din  = d;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      sent_q.delete();
      rx_n = 0;
    end
    idle = (exp_q.size() == 0);
    if (idle) begin
      exp_v = 5'b10000;
    end else begin
      e     = exp_q.pop_front();
      exp_v = {1'b0, 1'b1, e};
    end
    got_v = {ready, busy, done, sout_valid, sout};
    check("outs{rdy,busy,done,vld,sout}", 32'(got_v), 32'(exp_v));

    // Receiver side: rebuild the word from valid bits, compare on done.
    if (sout_valid && rx_n < W) begin
      rx_word = {rx_word[W-2:0], sout};
      rx_n++;
    end
    if (done) begin
      if (sent_q.size() == 0) begin
        check("rx_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] s;
        s = sent_q.pop_front();
        check("rx_word", 32'(rx_word), 32'(s));
        check("rx_bits", 32'(rx_n), 32'(W));
        if (rx_word == s) words_ok++;
        $display("word tx=0x%02h rx=0x%02h", s, rx_word);
      end
      rx_n = 0;
    end

    // Model: the upcoming edge accepts a word only from idle and only without reset.
    if (idle && load && !rst) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back({1'b0, 1'b1, din[i]});
`ifdef PISO_PARITY_EN
      exp_q.push_back({1'b0, 1'b1, ^din});
`endif
      exp_q.push_back(3'b100);
      sent_q.push_back(din);
      accepts++;
    end
  endtask

  initial begin
    int budget;
    int start_ok;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Single frame 0xA5.
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00);

    // 0x3C with ignored load pulses mid-frame.
    step(1'b0, 1'b1, 8'h3C);
    for (int c = 1; c <= 12; c++)
      step(1'b0, (c == 2 || c == 5), (c == 2 || c == 5) ? 8'hFF : 8'h00);

    // Reset mid-frame, then a clean frame.
    step(1'b0, 1'b1, 8'hFF);
    for (int c = 1; c <= 3; c++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h81);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00);

    // Parity-sensitive words.
    step(1'b0, 1'b1, 8'h07);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00);

    // Reset and load on the same edge.
    step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Back-to-back frames with load tied high and random data.
    start_ok = words_ok;
    accepts  = 0;
    budget   = 100 * (W + 3) + 50;
    while (accepts < 100 && budget > 0) begin
      step(1'b0, 1'b1, W'($urandom));
      budget--;
    end
    check("stream_budget", 32'(accepts), 32'd100);
    for (int i = 0; i < W + 6; i++) step(1'b0, 1'b0, W'($urandom));
    check("stream_words_ok", 32'(words_ok - start_ok), 32'd100);
    check("model_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter, the send end of the team's 8-bit serial shift-register link. It captures a parallel word on a load handshake and shifts it out one bit per clock, MSB first, with a qualifying strobe. Its `sout`/`sout_valid` pair feeds the SIPO receiver chain directly (`sout_valid` gates the receiver's shift clock/enable), so a word loaded here is reconstructed at the receiver with identical bit positions.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2..32.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `load`  input  1: load request; sampled only while `ready`=1.
- `din`  input  WIDTH: parallel word, captured on the accepted `load` edge.
- `ready`  output  1: high in IDLE only; transmitter can accept a word.
- `sout`  output  1: serial data out; 0 when not transmitting.
- `sout_valid`  output  1: high in every cycle a data (or parity) bit is driven on `sout`.
- `busy`  output  1: high from the first bit through the DONE cycle.
- `done`  output  1: single-cycle pulse after the last bit.

## Operation
- FSM states: IDLE, SHIFT, PARITY (only with `PISO_PARITY_EN`), DONE.
- IDLE: `ready`=1, `busy`=0, `sout`=0, `sout_valid`=0. On `load`=1 at a rising edge, capture `din` into the WIDTH-bit shift register, clear the bit counter, and move to SHIFT.
- SHIFT: `sout` = shift register MSB, `sout_valid`=1, `busy`=1. Each edge shifts left by one, fills the LSB with 0, and increments the counter ($clog2(WIDTH) bits). When the counter equals WIDTH-1, go to PARITY if enabled, otherwise DONE.
- PARITY: `sout` = even parity (XOR) of the captured word, `sout_valid`=1, `busy`=1, for one cycle. Then go to DONE.
- DONE: `done`=1, `busy`=1, `sout`=0, `sout_valid`=0, `ready`=0, for one cycle. Then go to IDLE.
- `load` outside IDLE is ignored; `din` is not re-sampled while a frame is in flight.
- Parity is computed at capture time and registered; later changes to `din` have no effect.
- All outputs are decoded from registered state; no combinational path from `load` or `din` to any output.

## Timing
- Reset values: state=IDLE, shift register=0, counter=0, `ready`=1, `sout`=0, `sout_valid`=0, `busy`=0, `done`=0.
- Load accepted at edge k:
  - bit `din[WIDTH-1]` is on `sout` during cycle k+1;
  - `din[0]` is on `sout` during cycle k+WIDTH.
- Without parity:
  - `done` is high in cycle k+WIDTH+1;
  - `ready` is high again from cycle k+WIDTH+2;
  - frame period is WIDTH+2 cycles.
- With parity:
  - the parity bit is on `sout` in cycle k+WIDTH+1;
  - `done` is high in cycle k+WIDTH+2;
  - frame period is WIDTH+3 cycles.
- `load` held high continuously: a new word is accepted on the first edge with `ready`=1, giving back-to-back frames at the frame period.
- Reset asserted mid-frame: all outputs take reset values immediately (asynchronously), the in-flight word is discarded, and no `done` pulse is produced.
- `rst` and `load` high on the same edge: reset wins and nothing is captured.
- Release of `rst` is synchronised by the integrating top level; the first accepted `load` is the first edge with `rst`=0.

## Configuration
- `PISO_PARITY_EN` defined: the PARITY state and parity register are compiled in. One extra even-parity bit follows the LSB with `sout_valid`=1, adding one cycle of latency and period.
- `PISO_PARITY_EN` undefined: no PARITY state and no parity logic; SHIFT goes directly to DONE.

## Test plan
- Reset, then load `din`=0xA5 -> `sout` = 1,0,1,0,0,1,0,1 in cycles 1..8 with `sout_valid`=1; `done`=1 in cycle 9 only; `ready`=1 in cycle 10.
- Load 0x3C, then pulse `load` with `din`=0xFF in cycles 2 and 5 -> serial stream is still 0,0,1,1,1,1,0,0; the second word is never transmitted; `ready` stays 0 until cycle 10.
- Load 0xFF, assert `rst` in cycle 4 -> `sout`=0, `busy`=0, `ready`=1 at once; no `done` pulse; a following load of 0x81 transmits 1,0,0,0,0,0,0,1 cleanly.
- With `PISO_PARITY_EN`: 0xA5 -> parity bit 0 in cycle 9 and `done` in cycle 10; 0x07 -> parity bit 1.
- `load` tied high with a random `din` sequence, `sout` driving a SIPO receiver enabled by `sout_valid` -> after each `done`, the receiver word equals the transmitted word for 100 words.
- `rst` and `load` asserted on the same edge with `din`=0x55 -> nothing captured; `sout_valid` stays 0 in the next cycle.
